// File: rtl/level_banner_ctrl_pkg.sv
// Shared text/HUD definitions: banner state
// encoding, default frame constants, level clamp.
package level_banner_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLINK = 2'd2,
    ST_DONE  = 2'd3
  } banner_state_e;

  localparam int DEF_SHOW_FRAMES  = 120;
  localparam int DEF_BLINK_FRAMES = 60;
  localparam int DEF_BLINK_PERIOD = 8;

  localparam logic [3:0] LVL_MIN = 4'd1;
  localparam logic [3:0] LVL_MAX = 4'd9;

  function automatic logic [3:0] clamp_level(
    input logic [3:0] l
  );
    if (l == 4'd0)
      return LVL_MIN;
    else if (l > LVL_MAX)
      return LVL_MAX;
    else
      return l;
  endfunction

endpackage

// File: rtl/level_banner_ctrl_edge_detect_rise.sv
// Rising-edge detector: registered history,
// pulse while input high and history low.
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic prev;

  // remember last cycle's input
  always_ff @(posedge clk) begin
    if (rst)
      prev <= 1'b0;
    else
      prev <= d;
  end

  assign pulse = d & ~prev;

endmodule

// File: rtl/level_banner_ctrl.sv
// Level banner sequencer: steady show, blink
// phase, one-cycle done; frame tick from vsync.
module level_banner_ctrl
  import level_banner_ctrl_pkg::*;
#(
  parameter int SHOW_FRAMES  = DEF_SHOW_FRAMES,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
  parameter int BLINK_PERIOD = DEF_BLINK_PERIOD
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       level_req,
  input  logic [3:0] level_in,
  input  logic       abort,
  output logic [3:0] level_out,
  output logic       banner_en,
  output logic       busy,
  output logic       done
);

  localparam int MAXP =
    (SHOW_FRAMES > BLINK_FRAMES)
      ? ((SHOW_FRAMES > BLINK_PERIOD)
          ? SHOW_FRAMES : BLINK_PERIOD)
      : ((BLINK_FRAMES > BLINK_PERIOD)
          ? BLINK_FRAMES : BLINK_PERIOD);
  localparam int CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] SHOW_LAST =
    CW'(SHOW_FRAMES - 1);
  localparam logic [CW-1:0] BLINK_LAST =
    CW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] PER_LAST =
    CW'(BLINK_PERIOD - 1);

  banner_state_e   state, state_n;
  logic [CW-1:0]   frame_cnt, frame_n;
  logic [CW-1:0]   blink_cnt, blink_n;
  logic [3:0]      lvl_n;
  logic            ban_n, busy_n, done_n;
  logic            tick;

  edge_detect_rise u_vs_edge (
    .clk   (pclk),
    .rst   (rst),
    .d     (vsync_in),
    .pulse (tick)
  );

  // state, counters and registered outputs
  always_ff @(posedge pclk) begin
    if (rst) begin
      state     <= ST_IDLE;
      frame_cnt <= '0;
      blink_cnt <= '0;
      level_out <= LVL_MIN;
      banner_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_n;
      blink_cnt <= blink_n;
      level_out <= lvl_n;
      banner_en <= ban_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // next state and next output values
  always_comb begin
    state_n = state;
    frame_n = frame_cnt;
    blink_n = blink_cnt;
    lvl_n   = level_out;
    ban_n   = banner_en;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (level_req && !abort) begin
          state_n = ST_SHOW;
          lvl_n   = clamp_level(level_in);
          frame_n = '0;
          blink_n = '0;
          ban_n   = 1'b1;
          busy_n  = 1'b1;
        end
      end
      ST_SHOW: begin
        if (abort) begin
          state_n = ST_IDLE;
          frame_n = '0;
          blink_n = '0;
          ban_n   = 1'b0;
          busy_n  = 1'b0;
        end else if (tick) begin
          if (frame_cnt == SHOW_LAST) begin
            state_n = ST_BLINK;
            frame_n = '0;
            blink_n = '0;
            ban_n   = 1'b1;
          end else begin
            frame_n = frame_cnt + 1'b1;
          end
        end
      end
      ST_BLINK: begin
        if (abort) begin
          state_n = ST_IDLE;
          frame_n = '0;
          blink_n = '0;
          ban_n   = 1'b0;
          busy_n  = 1'b0;
        end else if (tick) begin
          frame_n = frame_cnt + 1'b1;
          if (blink_cnt == PER_LAST) begin
            ban_n   = ~banner_en;
            blink_n = '0;
          end else begin
            blink_n = blink_cnt + 1'b1;
          end
          if (frame_cnt == BLINK_LAST) begin
            state_n = ST_DONE;
            frame_n = '0;
            blink_n = '0;
            ban_n   = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        ban_n   = 1'b0;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_level_banner_ctrl.sv
// Scoreboard bench for level_banner_ctrl: a phase
// model queues expected outputs, a monitor checks.
module tb_level_banner_ctrl;

  localparam int SF = 3;
  localparam int BF = 4;
  localparam int BP = 2;

  logic       pclk = 1'b0;
  logic       rst;
  logic       vsync_in;
  logic       level_req;
  logic [3:0] level_in;
  logic       abort;
  logic [3:0] level_out;
  logic       banner_en;
  logic       busy;
  logic       done;

  level_banner_ctrl #(
    .SHOW_FRAMES  (SF),
    .BLINK_FRAMES (BF),
    .BLINK_PERIOD (BP)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .vsync_in  (vsync_in),
    .level_req (level_req),
    .level_in  (level_in),
    .abort     (abort),
    .level_out (level_out),
    .banner_en (banner_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [6:0] expq[$];

  // reference model: phase name plus ticks seen
  // in the current phase, outputs derived from it
  int m_phase = 0;
  int m_ticks = 0;
  int m_lvl = 1;
  bit m_prev = 1'b0;

  function automatic logic [6:0] model_out();
    bit b;
    bit bz;
    bit dn;
    b  = 1'b0;
    bz = (m_phase == 1) || (m_phase == 2);
    dn = (m_phase == 3);
    if (m_phase == 1)
      b = 1'b1;
    else if (m_phase == 2)
      b = ((m_ticks / BP) % 2) == 0;
    return {4'(m_lvl), b, bz, dn};
  endfunction

  task automatic model_step(
    input bit r, input bit vs, input bit rq,
    input int lv, input bit ab
  );
    bit tk;
    if (r) begin
      m_phase = 0;
      m_ticks = 0;
      m_lvl   = 1;
      m_prev  = 1'b0;
      return;
    end
    tk = vs && !m_prev;
    m_prev = vs;
    case (m_phase)
      0: if (rq && !ab) begin
        m_phase = 1;
        m_ticks = 0;
        m_lvl = (lv == 0) ? 1 : (lv > 9) ? 9 : lv;
      end
      1: if (ab) m_phase = 0;
         else if (tk) begin
           m_ticks++;
           if (m_ticks == SF) begin
             m_phase = 2;
             m_ticks = 0;
           end
         end
      2: if (ab) m_phase = 0;
         else if (tk) begin
           m_ticks++;
           if (m_ticks == BF) m_phase = 3;
         end
      default: m_phase = 0;
    endcase
  endtask

  task automatic cyc_drive(
    input bit r, input bit vs, input bit rq,
    input int lv, input bit ab
  );
    @(negedge pclk);
    rst       = r;
    vsync_in  = vs;
    level_req = rq;
    level_in  = 4'(lv);
    abort     = ab;
    model_step(r, vs, rq, lv, ab);
    expq.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc_drive(0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_drive(0, 1, 0, 0, 0);
      cyc_drive(0, 1, 0, 0, 0);
      cyc_drive(0, 0, 0, 0, 0);
      cyc_drive(0, 0, 0, 0, 0);
    end
  endtask

  // monitor: one expected output set per edge
  initial begin
    logic [6:0] e;
    logic [6:0] g;
    forever begin
      @(posedge pclk);
      #1;
      cyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        g = {level_out, banner_en, busy, done};
        checks++;
        if (g !== e) begin
          failures++;
          $display(
            "FAIL outputs cyc=%0d got lvl=%0d ban=%b busy=%b done=%b exp lvl=%0d ban=%b busy=%b done=%b",
            cyc, g[6:3], g[2], g[1], g[0],
            e[6:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    bit vs;
    int lim;
    cyc_drive(1, 0, 0, 0, 0);
    cyc_drive(1, 0, 0, 0, 0);
    idle(3);
    // nominal run, with late request ignored
    cyc_drive(0, 0, 1, 5, 0);
    ticks(1);
    cyc_drive(0, 0, 1, 7, 0);
    ticks(8);
    // clamps
    cyc_drive(0, 0, 1, 0, 0);
    ticks(8);
    cyc_drive(0, 0, 1, 12, 0);
    ticks(8);
    // abort in blink, then abort+req in idle
    cyc_drive(0, 0, 1, 5, 0);
    ticks(4);
    cyc_drive(0, 0, 0, 0, 1);
    idle(3);
    cyc_drive(0, 0, 1, 6, 1);
    idle(3);
    ticks(2);
    // reset mid-show
    cyc_drive(0, 0, 1, 5, 0);
    ticks(1);
    cyc_drive(1, 0, 0, 0, 0);
    idle(2);
    cyc_drive(0, 0, 1, 3, 0);
    ticks(8);
    // tick coincident with request
    cyc_drive(0, 1, 1, 8, 0);
    cyc_drive(0, 0, 0, 0, 0);
    ticks(8);
    // randomized traffic
    vs = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) vs = ~vs;
      cyc_drive(
        $urandom_range(0, 299) == 0,
        vs,
        $urandom_range(0, 7) == 0,
        int'($urandom_range(0, 15)),
        $urandom_range(0, 79) == 0);
    end
    idle(2);
    lim = 0;
    while (expq.size() > 0 && lim < 20) begin
      @(posedge pclk);
      lim++;
    end
    #2;
    if (expq.size() > 0) begin
      failures++;
      $display("FAIL drain left=%0d need=0",
               expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
